fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Operand forwarding and load-use hazard control for the 5-stage pipeline. Tracks the destination register of each instruction in EX, MEM and WB. Produces registered 2-bit selects for the two-level EX-stage ALU operand muxes, which are built from 2:1 mux cells. Asserts a combinational stall that holds PC and IF/ID and injects a bubble into EX on load-use dependencies.

## Interface
Parameters:
- REG_W, 5, register index width
- ZERO_REG, 31, index of XZR; never a forwarding source or hazard
- CNT_W, 16, width of the performance counters

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low; sampled on the rising edge of clk
- id_valid  input  1  the ID stage holds a real instruction
- id_rn, id_rm  input  REG_W  source register indices of the ID instruction
- id_uses_rn, id_uses_rm  input  1  the ID instruction reads rn / rm
- id_rd  input  REG_W  destination register of the ID instruction
- id_reg_write  input  1  the ID instruction writes id_rd
- id_mem_read  input  1  the ID instruction is a load (LDUR)
- flush  input  1  kill the ID instruction this cycle (taken branch)
- stall  output  1  hold PC and IF/ID, insert bubble into EX (combinational)
- fwd_a, fwd_b  output  2  EX operand selects, registered: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write-back data; 11 never driven
- stall_cnt, fwd_cnt  output  CNT_W  saturating counts of stall cycles and of forwarded operands

## Operation
- Internal entries exist for EX, MEM and WB. Each entry holds: valid, rd, reg_write, mem_read.
- Every cycle the entries shift: EX→MEM→WB. EX is loaded from the ID inputs, or with a bubble (valid=0) when stall=1, flush=1 or id_valid=0.
- A producer P matches source register s when all of the following hold:
  - P.valid=1 and P.reg_write=1
  - P.rd == s and s != ZERO_REG
  - the corresponding id_uses_* is 1
- Load-use hazard:
  - stall = id_valid & ~flush & EX.valid & EX.mem_read & (EX matches id_rn, or EX matches id_rm).
  - MEM-stage loads never stall; they are forwarded from MEM/WB.
- Forward selects for the instruction entering EX, computed from ID sources against the current EX and MEM entries (those entries become MEM and WB next cycle):
  - Current EX matches (and is not a load): next fwd = 01.
  - Otherwise current MEM matches: next fwd = 10.
  - Otherwise: next fwd = 00.
  - The newer producer (EX) has priority over MEM when both match.
- When EX is loaded with a bubble, fwd_a and fwd_b load 00.
- The WB→ID case is not forwarded by this block. The register file writes on the falling edge, so a same-cycle read sees the new value.
- Counters:
  - stall_cnt increments each cycle stall=1.
  - fwd_cnt increments by the number of the two next-cycle selects that are nonzero (0, 1 or 2).
  - Both saturate at all-ones; neither wraps.

## Timing
- Reset (reset=0 at a rising edge), effective on that edge:
  - all entries valid=0
  - fwd_a=fwd_b=00
  - stall_cnt=fwd_cnt=0
  - stall=0 from the following cycle, because it is combinational and no EX entry is valid.
- Reset held low for several cycles: state stays cleared and ID inputs are ignored.
- Reset asserted mid-stall drops stall the cycle after the reset edge.
- stall and the forward decision are combinational from ID inputs and the EX/MEM entries, within the same cycle.
- fwd_a and fwd_b change only on the rising edge and are valid for the whole cycle the instruction spends in EX.
- Load-use costs exactly 1 stall cycle:
  - In the next cycle the load is in MEM and the consumer is re-presented in ID.
  - The consumer then gets fwd=10.
- flush and a load-use condition in the same cycle: flush wins, stall=0 and EX loads a bubble.
- Both operands matching different producers: fwd_a and fwd_b are resolved independently.
- Both operands naming the same register: both selects take the same value.

## Test plan
- Reset behaviour: drive reset=0 for 2 cycles with a valid, dependent ID instruction → after release stall=0, fwd_a=fwd_b=00, both counters 0.
- Back-to-back forwarding, ADD X1,X2,X3 then SUB X4,X1,X1 → when SUB is in EX, fwd_a=fwd_b=01; fwd_cnt=2.
- Forwarding distance 2, ADD X5 then an unrelated instruction, then ORR X6,X7,X5 → fwd_a=00 and fwd_b=10.
- Priority, ADD X1 then ADD X1 then AND X2,X1,X9 → fwd_a=01 (newer producer); fwd_b=00.
- Load-use and XZR:
  - LDUR X3 then ADD X4,X3,X0 → stall=1 for exactly 1 cycle, then fwd_a=10; stall_cnt=1.
  - Repeat with the load writing XZR (X31) and ADD reading X31 → no stall, fwd=00.
- Flush and saturation:
  - Load-use condition together with flush=1 → stall=0; the next EX entry is a bubble with fwd=00.
  - Force more than 2^CNT_W stall cycles → stall_cnt holds at all-ones.

Source files
------------

// File: rtl/fwd_hazard_if.sv
// ID-stage hazard/forwarding bus.
// The ID stage is the master; the hazard unit is the slave.
interface fwd_hazard_if #(
  parameter int REG_W = 5
);
  logic             id_valid;
  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic             id_uses_rn;
  logic             id_uses_rm;
  logic [REG_W-1:0] id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             flush;
  logic             stall;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  modport master (
    output id_valid, id_rn, id_rm,
    output id_uses_rn, id_uses_rm,
    output id_rd, id_reg_write,
    output id_mem_read, flush,
    input  stall, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_rn, id_rm,
    input  id_uses_rn, id_uses_rm,
    input  id_rd, id_reg_write,
    input  id_mem_read, flush,
    output stall, fwd_a, fwd_b
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and load-use stall
// generation for the 5-stage pipeline.
module fwd_hazard_unit #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  fwd_hazard_if.slave      id,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] fwd_cnt
);

  localparam logic [REG_W-1:0] ZR =
    REG_W'(ZERO_REG);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } ent_t;

  ent_t ex_q;
  ent_t mem_q;
  ent_t wb_q;
  ent_t ex_d;

  logic       ex_a;
  logic       ex_b;
  logic       mem_a;
  logic       mem_b;
  logic       load_use;
  logic       bubble;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic [1:0] inc;
  logic [CNT_W:0] fsum;

  function automatic logic hit(
    input ent_t             p,
    input logic [REG_W-1:0] s,
    input logic             uses
  );
    return p.valid & p.reg_write &
           (p.rd == s) & (s != ZR) & uses;
  endfunction

  assign id.stall = id.id_valid & ~id.flush &
                    load_use;

  // Producer matching, next selects and next EX entry.
  always_comb begin
    ex_a  = hit(ex_q, id.id_rn, id.id_uses_rn);
    ex_b  = hit(ex_q, id.id_rm, id.id_uses_rm);
    mem_a = hit(mem_q, id.id_rn, id.id_uses_rn);
    mem_b = hit(mem_q, id.id_rm, id.id_uses_rm);

    load_use = ex_q.mem_read & (ex_a | ex_b);
    bubble   = ~id.id_valid | id.flush | load_use;

    // EX is the newer producer and wins over MEM.
    if (bubble)     sel_a = 2'b00;
    else if (ex_a)  sel_a = 2'b01;
    else if (mem_a) sel_a = 2'b10;
    else            sel_a = 2'b00;

    if (bubble)     sel_b = 2'b00;
    else if (ex_b)  sel_b = 2'b01;
    else if (mem_b) sel_b = 2'b10;
    else            sel_b = 2'b00;

    ex_d = '0;
    if (!bubble) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = id.id_rd;
      ex_d.reg_write = id.id_reg_write;
      ex_d.mem_read  = id.id_mem_read;
    end

    inc  = {1'b0, sel_a != 2'b00} +
           {1'b0, sel_b != 2'b00};
    fsum = {1'b0, fwd_cnt} +
           {{(CNT_W-1){1'b0}}, inc};
  end

  // Pipeline entry shift and registered selects.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      id.fwd_a <= 2'b00;
      id.fwd_b <= 2'b00;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= ex_q;
      wb_q     <= mem_q;
      id.fwd_a <= sel_a;
      id.fwd_b <= sel_b;
    end
  end

  // Saturating stall and forward counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (id.stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (fsum[CNT_W])
        fwd_cnt <= '1;
      else
        fwd_cnt <= fsum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed table,
// corner sequences and random vs a stage model.
module tb_fwd_hazard_unit;

  localparam int REG_W = 5;
  localparam int ZR    = 31;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] fwd_cnt;

  fwd_hazard_if #(.REG_W(REG_W)) bus();

  fwd_hazard_unit #(
    .REG_W(REG_W),
    .ZERO_REG(ZR),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id(bus.slave),
    .stall_cnt(stall_cnt),
    .fwd_cnt(fwd_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Reference: list of in-flight producers,
  // index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } prod_t;

  prod_t pipe[3];
  int m_fa = 0;
  int m_fb = 0;
  int m_sc = 0;
  int m_fc = 0;

  // 0 none, 1 from EX, 2 from MEM, 3 load hazard.
  function automatic int pick(input int s,
                              input bit uses);
    if (!uses || s == ZR) return 0;
    for (int k = 0; k < 2; k++)
      if (pipe[k].v && pipe[k].rw &&
          pipe[k].rd == s)
        return (k == 0) ?
          (pipe[0].mr ? 3 : 1) : 2;
    return 0;
  endfunction

  function automatic bit m_stall();
    int sa;
    int sb;
    sa = pick(int'(bus.id_rn), bus.id_uses_rn);
    sb = pick(int'(bus.id_rm), bus.id_uses_rm);
    return bus.id_valid && !bus.flush &&
           (sa == 3 || sb == 3);
  endfunction

  task automatic drive(input bit v,
                       input int rn, input int rm,
                       input bit urn, input bit urm,
                       input int rd, input bit rw,
                       input bit mr, input bit fl);
    bus.id_valid     = v;
    bus.id_rn        = REG_W'(rn);
    bus.id_rm        = REG_W'(rm);
    bus.id_uses_rn   = urn;
    bus.id_uses_rm   = urm;
    bus.id_rd        = REG_W'(rd);
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.flush        = fl;
  endtask

  task automatic sample();
    @(negedge clk);
    chk("model_stall", bus.stall, int'(m_stall()));
    chk("model_fwd_a", bus.fwd_a, m_fa);
    chk("model_fwd_b", bus.fwd_b, m_fb);
    chk("model_stall_cnt", stall_cnt, m_sc);
    chk("model_fwd_cnt", fwd_cnt, m_fc);
  endtask

  task automatic advance();
    int sa;
    int sb;
    bit st;
    bit enter;
    sa = pick(int'(bus.id_rn), bus.id_uses_rn);
    sb = pick(int'(bus.id_rm), bus.id_uses_rm);
    st = m_stall();
    if (!reset) begin
      for (int k = 0; k < 3; k++)
        pipe[k] = '{0, 0, 0, 0};
      m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
    end else begin
      enter = bus.id_valid && !bus.flush && !st;
      m_sc = (m_sc + st > CMAX) ? CMAX : m_sc + st;
      m_fa = enter ? sa : 0;
      m_fb = enter ? sb : 0;
      m_fc = m_fc + (m_fa != 0) + (m_fb != 0);
      if (m_fc > CMAX) m_fc = CMAX;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (enter)
        pipe[0] = '{1, int'(bus.id_rd),
                    bus.id_reg_write,
                    bus.id_mem_read};
      else
        pipe[0] = '{0, 0, 0, 0};
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit v; int rn; int rm; bit urn; bit urm;
    int rd; bit rw; bit mr; bit fl;
    bit s; int fa; int fb; int sc; int fc;
  } vec_t;

  function automatic vec_t mk(
    bit v, int rn, int rm, bit urn, bit urm,
    int rd, bit rw, bit mr, bit fl,
    bit s, int fa, int fb, int sc, int fc);
    vec_t t;
    t = '{v, rn, rm, urn, urm, rd, rw, mr, fl,
          s, fa, fb, sc, fc};
    return t;
  endfunction

  function automatic int rreg();
    int k;
    k = $urandom_range(0, 4);
    return (k == 4) ? ZR : k;
  endfunction

  vec_t tv[27];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    // ID fields: v rn rm urn urm rd rw mr fl
    // expected : stall fwd_a fwd_b s_cnt f_cnt
    tv[0]  = mk(0, 0, 0,0,0, 0,0,0,0, 0,0,0,0,0);
    tv[1]  = mk(1, 2, 3,1,1, 1,1,0,0, 0,0,0,0,0);
    tv[2]  = mk(1, 1, 1,1,1, 4,1,0,0, 0,0,0,0,0);
    tv[3]  = mk(0, 0, 0,0,0, 0,0,0,0, 0,1,1,0,2);
    tv[4]  = mk(1, 2, 3,1,1, 5,1,0,0, 0,0,0,0,2);
    tv[5]  = mk(1, 2, 3,1,1, 8,1,0,0, 0,0,0,0,2);
    tv[6]  = mk(1, 7, 5,1,1, 6,1,0,0, 0,0,0,0,2);
    tv[7]  = mk(0, 0, 0,0,0, 0,0,0,0, 0,0,2,0,3);
    tv[8]  = mk(1, 2, 3,1,1, 1,1,0,0, 0,0,0,0,3);
    tv[9]  = mk(1, 2, 3,1,1, 1,1,0,0, 0,0,0,0,3);
    tv[10] = mk(1, 1, 9,1,1, 2,1,0,0, 0,0,0,0,3);
    tv[11] = mk(0, 0, 0,0,0, 0,0,0,0, 0,1,0,0,4);
    tv[12] = mk(1,10, 0,1,0, 3,1,1,0, 0,0,0,0,4);
    tv[13] = mk(1, 3, 0,1,1, 4,1,0,0, 1,0,0,0,4);
    tv[14] = mk(1, 3, 0,1,1, 4,1,0,0, 0,0,0,1,4);
    tv[15] = mk(0, 0, 0,0,0, 0,0,0,0, 0,2,0,1,5);
    tv[16] = mk(1,10, 0,1,0,31,1,1,0, 0,0,0,1,5);
    tv[17] = mk(1,31,31,1,1, 4,1,0,0, 0,0,0,1,5);
    tv[18] = mk(0, 0, 0,0,0, 0,0,0,0, 0,0,0,1,5);
    tv[19] = mk(1,10, 0,1,0, 3,1,1,0, 0,0,0,1,5);
    tv[20] = mk(1, 3, 3,1,1, 4,1,0,1, 0,0,0,1,5);
    tv[21] = mk(1, 4, 4,1,1, 7,1,0,0, 0,0,0,1,5);
    tv[22] = mk(0, 0, 0,0,0, 0,0,0,0, 0,0,0,1,5);
    tv[23] = mk(1, 2, 3,1,1,11,1,0,0, 0,0,0,1,5);
    tv[24] = mk(1, 2, 3,1,1,12,1,0,0, 0,0,0,1,5);
    tv[25] = mk(1,11,12,1,1,13,1,0,0, 0,0,0,1,5);
    tv[26] = mk(0, 0, 0,0,0, 0,0,0,0, 0,2,1,1,7);

    // Reset held with a dependent load in ID.
    reset = 1'b0;
    drive(1, 3, 0, 1, 0, 3, 1, 1, 0);
    advance();
    advance();
    reset = 1'b1;
    sample();
    chk("rst_stall", bus.stall, 0);
    chk("rst_fwd_a", bus.fwd_a, 0);
    chk("rst_fwd_b", bus.fwd_b, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_fwd_cnt", fwd_cnt, 0);
    advance();
    sample();
    chk("lu_before_rst", bus.stall, 1);
    // Reset lands on a stalling cycle.
    reset = 1'b0;
    advance();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("rst_mid_stall", bus.stall, 0);
    chk("rst_mid_scnt", stall_cnt, 0);
    advance();

    // Directed table.
    foreach (tv[i]) begin
      drive(tv[i].v, tv[i].rn, tv[i].rm,
            tv[i].urn, tv[i].urm, tv[i].rd,
            tv[i].rw, tv[i].mr, tv[i].fl);
      sample();
      chk($sformatf("tv%0d_stall", i),
          bus.stall, int'(tv[i].s));
      chk($sformatf("tv%0d_fwd_a", i),
          bus.fwd_a, tv[i].fa);
      chk($sformatf("tv%0d_fwd_b", i),
          bus.fwd_b, tv[i].fb);
      chk($sformatf("tv%0d_scnt", i),
          stall_cnt, tv[i].sc);
      chk($sformatf("tv%0d_fcnt", i),
          fwd_cnt, tv[i].fc);
      advance();
    end

    // Self-dependent load: one stall every
    // two cycles, drives both counters to max.
    drive(1, 3, 0, 1, 0, 3, 1, 1, 0);
    for (int i = 0; i < 700; i++) begin
      sample();
      advance();
    end
    sample();
    chk("sat_stall_cnt", stall_cnt, CMAX);
    chk("sat_fwd_cnt", fwd_cnt, CMAX);
    advance();

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    reset = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 9) != 0,
            rreg(), rreg(),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0,
            rreg(),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0);
      sample();
      advance();
    end
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    sample();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
